// File: rtl/serial_sub.sv
// rtl/serial_sub.sv - bit-serial subtractor a - b - bin, LSB first, WIDTH cycles per operation
// Optional zero/ovf flag ports are built in when SERIAL_SUB_FLAGS_EN is defined.
module serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             br_q, br_d;
  // Holds in_ready low until the first clock edge after reset is released.
  logic             live_q, live_d;

  logic a_bit, b_bit, d_bit, br_next;

  assign a_bit   = a_q[0];
  assign b_bit   = b_q[0];
  assign d_bit   = a_bit ^ b_bit ^ br_q;
  assign br_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);

`ifdef SERIAL_SUB_FLAGS_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic zero_q, zero_d;
  logic ovf_q, ovf_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      live_q  <= 1'b0;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      live_q  <= live_d;
`ifdef SERIAL_SUB_FLAGS_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    live_d  = 1'b1;
`ifdef SERIAL_SUB_FLAGS_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && live_q) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = SHIFT;
`ifdef SERIAL_SUB_FLAGS_EN
          a_msb_d = a[WIDTH-1];
          b_msb_d = b[WIDTH-1];
`endif
        end
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {d_bit, res_q[WIDTH-1:1]};
        br_d  = br_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = DONE;
`ifdef SERIAL_SUB_FLAGS_EN
          zero_d  = (res_d == '0);
          ovf_d   = (a_msb_q != b_msb_q) && (d_bit != a_msb_q);
`endif
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE) && live_q;
  assign out_valid = (state_q == DONE);
  assign diff      = res_q;
  assign bout      = br_q;
`ifdef SERIAL_SUB_FLAGS_EN
  assign zero      = zero_q;
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_sub.sv
// tb/tb_serial_sub.sv - directed self-checking bench for serial_sub (WIDTH=16)
// Flag checks are compiled in only when SERIAL_SUB_FLAGS_EN is defined.
module tb_serial_sub;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUB_FLAGS_EN
  logic         zero;
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;

  serial_sub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SERIAL_SUB_FLAGS_EN
    ,
    .zero      (zero),
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi);
    @(negedge clk);
    a        = av;
    b        = bv;
    bin      = bi;
    in_valid = 1'b1;
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = 16'hDEAD;
    b        = 16'hBEEF;
    bin      = 1'b1;
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [W-1:0] exp_diff, input logic exp_bout,
                        input logic exp_zero, input logic exp_ovf);
    int lat;
    accept(av, bv, bi);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd16);
    chk({tag, "_diff"}, {16'd0, diff}, {16'd0, exp_diff});
    chk({tag, "_bout"}, {31'd0, bout}, {31'd0, exp_bout});
`ifdef SERIAL_SUB_FLAGS_EN
    chk({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
`endif
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ret_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_ret_out_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    bin       = 1'b0;

    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_diff", {16'd0, diff}, 32'd0);
    chk("rst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("rst_zero", {31'd0, zero}, 32'd0);
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready_clocked", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_in_ready_pre_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rel_in_ready_post_edge", {31'd0, in_ready}, 32'd1);

    run_op("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
    run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("binrow", 16'h0010, 16'h0010, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    run_op("sovf", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0, 1'b1);
    run_op("zero", 16'h0005, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Result held in DONE while new operands are offered and out_ready stays low.
    accept(16'h00FF, 16'h0F00, 1'b0);
    repeat (16) @(posedge clk);
    #1;
    chk("hold_enter_done", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b1;
    a        = 16'hAAAA;
    b        = 16'h5555;
    bin      = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_diff", {16'd0, diff}, 32'h0000_F1FF);
      chk("hold_bout", {31'd0, bout}, 32'd1);
`ifdef SERIAL_SUB_FLAGS_EN
      chk("hold_zero", {31'd0, zero}, 32'd0);
      chk("hold_ovf", {31'd0, ovf}, 32'd0);
`endif
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("hold_release_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("hold_not_accepted", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of an operation discards it.
    accept(16'h0000, 16'h0001, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_diff", {16'd0, diff}, 32'd0);
    chk("midrst_bout", {31'd0, bout}, 32'd0);
`ifdef SERIAL_SUB_FLAGS_EN
    chk("midrst_zero", {31'd0, zero}, 32'd0);
    chk("midrst_ovf", {31'd0, ovf}, 32'd0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_rel_pre_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("midrst_rel_post_edge", {31'd0, in_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen++;
    end
    chk("midrst_no_stale", seen, 32'd0);

    run_op("after_rst", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand and result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operand set a/b/bin presented.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand set.
REQ-006 SHALL have port a  input  WIDTH  minuend.
REQ-007 SHALL have port b  input  WIDTH  subtrahend.
REQ-008 SHALL have port bin  input  1  borrow-in.
REQ-009 SHALL have port out_valid  output  1  result on diff/bout is valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-012 SHALL have port bout  output  1  borrow-out, 1 when a < b + bin (unsigned).
REQ-013 SHALL have ports zero  output  1 (diff == 0) and ovf  output  1 (signed overflow), present only per REQ-031.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-015 SHALL assert in_ready only in IDLE; out_valid only in DONE.
REQ-016 IDLE: in_valid && in_ready at edge N SHALL capture a, b, bin, the MSB of a and the MSB of b; clear bit counter; go to SHIFT.
REQ-017 SHIFT: each edge SHALL process one bit, LSB first: d = a_i ^ b_i ^ br; br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br); br initialised from bin.
REQ-018 SHIFT: d SHALL be shifted into the result register from the MSB side; the operand registers SHALL shift right by one.
REQ-019 SHALL process exactly WIDTH bits; the last bit is processed at edge N+WIDTH, at which the FSM enters DONE.
REQ-020 SHALL assert out_valid after edge N+WIDTH (fixed latency WIDTH cycles from acceptance, independent of operand values).
REQ-021 SHALL set bout to the final br value.
REQ-022 DONE: diff, bout, zero and ovf SHALL be held stable while out_valid && !out_ready.
REQ-023 DONE: out_ready at edge M SHALL return the FSM to IDLE at edge M, deasserting out_valid and asserting in_ready.
REQ-024 SHALL provide no same-cycle DONE-to-SHIFT bypass; minimum issue interval is WIDTH+2 cycles.
REQ-025 SHALL ignore in_valid and operand changes in SHIFT and DONE.
REQ-026 SHALL not require out_ready to be asserted before out_valid, and SHALL not use it outside DONE.

Reset
REQ-027 rst high SHALL immediately force IDLE, bit counter 0, and operand, result and borrow registers to 0, regardless of clk.
REQ-028 During rst: in_ready=0, out_valid=0, diff=0, bout=0, zero=0, ovf=0.
REQ-029 in_ready SHALL rise to 1 on the first clk edge after rst is released.
REQ-030 Reset mid-SHIFT or in DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-031 Macro SERIAL_SUB_FLAGS_EN defined: ports zero and ovf SHALL exist and SHALL update with diff on entry to DONE.
- zero = (diff == 0).
- ovf = (a_msb != b_msb) && (diff_msb != a_msb), using the MSBs captured in REQ-016.
REQ-032 Macro SERIAL_SUB_FLAGS_EN undefined: ports zero and ovf and their logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=16, flags enabled unless stated)
REQ-033 a=0x1234, b=0x0234, bin=0 -> out_valid exactly 16 cycles after acceptance; diff=0x1000, bout=0, zero=0, ovf=0.
REQ-034 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. a=0x0010, b=0x0010, bin=1 -> diff=0xFFFF, bout=1.
REQ-035 a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1. a=0x0005, b=0x0005, bin=0 -> diff=0x0000, zero=1, bout=0.
REQ-036 out_ready held low 5 cycles in DONE while in_valid=1 with new operands -> diff/bout/flags stable, in_ready=0, new operands not accepted; out_ready=1 -> in_ready=1 next cycle.
REQ-037 rst pulsed after 7 SHIFT cycles -> out_valid=0, all outputs 0 immediately; in_ready=1 on the first edge after release; no stale result appears.
REQ-038 Build without SERIAL_SUB_FLAGS_EN, rerun REQ-033/034 -> identical diff, bout and timing.
